// File: rtl/bcd_timer_display.sv
// Multi-digit BCD up/down timer with 7-segment decode and IDLE/RUN/PAUSE/DONE control.
// Optional feature: define TIMER_BLINK_EN to blank the display on alternate prescale phases in DONE.
module bcd_timer_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  done,
  output logic                  running
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] NINES    = {DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          mode_q, mode_d;
  logic          done_q, running_q;
  logic          blank_c;

  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic is_terminal(input logic [CW-1:0] v, input logic up);
    return up ? (v == NINES) : (v == '0);
  endfunction

  // Decimal increment/decrement with ripple carry/borrow, digit by digit
  function automatic logic [CW-1:0] bcd_step(input logic [CW-1:0] v, input logic up);
    logic [CW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = v[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    mode_d  = mode_q;
    case (state_q)
      RUN: begin
        if (stop) begin
          state_d = PAUSE;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (!is_terminal(cnt_q, mode_q)) cnt_d = bcd_step(cnt_q, mode_q);
          if (is_terminal(cnt_d, mode_q)) state_d = DONE;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      DONE: begin
        if (load) begin
          cnt_d   = clamp_bcd(load_val);
          state_d = IDLE;
        end
      end
      default: begin
        if (load) begin
          cnt_d   = clamp_bcd(load_val);
          state_d = IDLE;
        end else if (start) begin
          mode_d  = mode;
          pre_d   = '0;
          state_d = is_terminal(cnt_q, mode) ? DONE : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pre_q     <= '0;
      mode_q    <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      mode_q    <= mode_d;
      done_q    <= (state_d == DONE);
      running_q <= (state_d == RUN);
    end
  end

`ifdef TIMER_BLINK_EN
  logic [PW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Phase counter restarts lit on every entry into DONE
  always_comb begin
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (state_q == DONE && state_d == DONE) begin
      if (blink_cnt_q == PRE_LAST) begin
        blink_ph_d = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + PW'(1);
        blink_ph_d  = blink_ph_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end

  assign blank_c = done_q & blink_ph_q;
`else
  assign blank_c = 1'b0;
`endif

  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = blank_c ? 7'b0000000 : seg7(cnt_q[4*i +: 4]);
    end
  end

  assign done    = done_q;
  assign running = running_q;

endmodule

// File: tb/tb_bcd_timer_display.sv
// Self-checking bench for bcd_timer_display: directed vector table, hand sequences, and
// randomized traffic compared against a decimal-arithmetic reference model.
module tb_bcd_timer_display;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned PRESCALE = 4;
  localparam int          TERM     = 9999;
`ifdef TIMER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam logic [27:0] SEG_ZEROS = {4{7'b0111111}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [15:0] load_val = '0;
  logic [27:0] seg;
  logic        done, running;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  bcd_timer_display #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
    .stop(stop), .mode(mode), .seg(seg), .done(done), .running(running)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] seg_of_dec(input int n);
    logic [27:0] r;
    int          x;
    r = '0;
    x = n;
    for (int i = 0; i < 4; i++) begin
      r[7*i +: 7] = seg_tbl[x % 10];
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int bcd_to_int(input logic [15:0] b);
    int r, p;
    r = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r += int'(b[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic int clamp_int(input logic [15:0] b);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  // Reference model: count kept as a plain decimal integer
  int m_cnt = 0, m_state = S_IDLE, m_pre = 0, m_dcyc = 0, m_prev = S_IDLE;
  bit m_up = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 0; m_state = S_IDLE; m_pre = 0; m_up = 1'b0; m_dcyc = 0;
      end else begin
        m_prev = m_state;
        if (m_state == S_RUN) begin
          if (stop) m_state = S_PAUSE;
          else if (m_pre == PRESCALE - 1) begin
            m_pre = 0;
            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == (m_up ? TERM : 0)) m_state = S_DONE;
          end else m_pre++;
        end else if (load) begin
          m_cnt = clamp_int(load_val);
          m_state = S_IDLE;
        end else if (start && m_state != S_DONE) begin
          m_up = mode;
          m_pre = 0;
          m_state = (m_cnt == (mode ? TERM : 0)) ? S_DONE : S_RUN;
        end
        if (m_state == S_DONE) m_dcyc = (m_prev == S_DONE) ? m_dcyc + 1 : 0;
        else m_dcyc = 0;
      end
    end
  end

  function automatic logic [27:0] model_seg();
    if (BLINK && m_state == S_DONE && ((m_dcyc / PRESCALE) % 2) == 1) return '0;
    return seg_of_dec(m_cnt);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("model_seg", 32'(seg), 32'(model_seg()));
        chk("model_done", 32'(done), 32'(m_state == S_DONE));
        chk("model_running", 32'(running), 32'(m_state == S_RUN));
      end
    end
  end

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        st;
    logic        sp;
    logic        md;
    int          n;
    logic [15:0] e_cnt;
    logic        e_done;
    logic        e_run;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic [15:0] lv, input logic st,
                              input logic sp, input logic md, input int n,
                              input logic [15:0] e_cnt, input logic e_done, input logic e_run);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.md = md; v.n = n;
    v.e_cnt = e_cnt; v.e_done = e_done; v.e_run = e_run;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic [15:0] lv, input logic st,
                       input logic sp, input logic md);
    load = ld; load_val = lv; start = st; stop = sp; mode = md;
  endtask

  task automatic pulse_rst_check(input string tag);
    #1 rst = 1'b1;
    #1;
    chk({tag, "_seg"}, 32'(seg), 32'(SEG_ZEROS));
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    #1 rst = 1'b0;
  endtask

  vec_t vt[$];

  initial begin
    // Directed table: {load, load_val, start, stop, mode, extra idle cycles, exp count, done, running}
    vt.push_back(mk(1, 16'h0003, 0, 0, 0, 0,  16'h0003, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 0,  16'h0003, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 2,  16'h0003, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 0,  16'h0002, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 3,  16'h0001, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 3,  16'h0000, 1, 0));
    vt.push_back(mk(1, 16'h0099, 0, 0, 0, 0,  16'h0099, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 3,  16'h0099, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 0,  16'h0100, 0, 1));
    vt.push_back(mk(1, 16'h1234, 0, 0, 0, 0,  16'h0100, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 0,  16'h0100, 0, 0));
    vt.push_back(mk(1, 16'h9998, 0, 0, 0, 0,  16'h9998, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 4,  16'h9999, 1, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 5,  16'h9999, 1, 0));
    vt.push_back(mk(1, 16'h00A5, 0, 0, 0, 0,  16'h0095, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 0,  16'h0095, 0, 1));
    vt.push_back(mk(0, 16'h0000, 1, 1, 0, 0,  16'h0095, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 1, 0, 4,  16'h0094, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 3,  16'h0093, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 19, 16'h0093, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 3,  16'h0093, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 0, 0, 0,  16'h0092, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 0,  16'h0092, 0, 0));
    vt.push_back(mk(1, 16'hFA9B, 1, 0, 1, 0,  16'h9999, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 1, 0,  16'h9999, 1, 0));
    vt.push_back(mk(1, 16'h1000, 0, 0, 0, 0,  16'h1000, 0, 0));
    vt.push_back(mk(0, 16'h0000, 1, 0, 0, 4,  16'h0999, 0, 1));
    vt.push_back(mk(0, 16'h0000, 0, 1, 0, 0,  16'h0999, 0, 0));

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_seg", 32'(seg), 32'(SEG_ZEROS));
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    foreach (vt[k]) begin
      drive(vt[k].ld, vt[k].lv, vt[k].st, vt[k].sp, vt[k].md);
      @(negedge clk);
      drive(0, 16'h0000, 0, 0, 0);
      repeat (vt[k].n) @(negedge clk);
      if (!(BLINK && vt[k].e_done))
        chk($sformatf("row%0d_seg", k), 32'(seg), 32'(seg_of_dec(bcd_to_int(vt[k].e_cnt))));
      chk($sformatf("row%0d_done", k), 32'(done), 32'(vt[k].e_done));
      chk($sformatf("row%0d_running", k), 32'(running), 32'(vt[k].e_run));
    end

    // Terminal count at start: DONE on the next edge without a tick
    drive(1, 16'h0000, 0, 0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 1, 0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 0);
    chk("term_start_done", 32'(done), 32'd1);
    chk("term_start_running", 32'(running), 32'd0);
    for (int c = 0; c < 9; c++) begin
      if (BLINK && ((c / 4) % 2) == 1) chk($sformatf("done_cyc%0d_seg", c), 32'(seg), 32'd0);
      else chk($sformatf("done_cyc%0d_seg", c), 32'(seg), 32'(SEG_ZEROS));
      @(negedge clk);
    end

    // Reset mid-RUN aborts the count with no further ticks
    drive(1, 16'h0005, 0, 0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 1, 0, 0);
    @(negedge clk);
    drive(0, 16'h0000, 0, 0, 0);
    repeat (6) @(negedge clk);
    chk("pre_rst_seg", 32'(seg), 32'(seg_of_dec(4)));
    pulse_rst_check("midrun_rst");
    repeat (12) @(negedge clk);
    chk("post_rst_seg", 32'(seg), 32'(SEG_ZEROS));
    chk("post_rst_running", 32'(running), 32'd0);

    // Randomized traffic checked every cycle by the model monitor
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] lv;
      int          sel;
      if ($urandom_range(0, 499) == 0) pulse_rst_check("rand_rst");
      sel = int'($urandom_range(0, 3));
      lv = 16'($urandom);
      if (sel == 1) lv = 16'($urandom_range(0, 3));
      else if (sel == 2) lv = 16'h9996 + 16'($urandom_range(0, 3));
      drive(($urandom_range(0, 15) == 0), lv, ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0), 1'($urandom));
      @(negedge clk);
    end
    drive(0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
